morse_sequencer: RTL and testbench

//   Converts one Morse symbol at a time (element count + dot/dash pattern) into

---
 rtl/morse_sequencer.sv | 122 ++++++++++++
 tb/tb_morse_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/morse_sequencer.sv
// rtl/morse_sequencer.sv - Morse symbol to unit-timed key on/off sequencer
// Takes one symbol per handshake and keys out its marks and gaps in units of UNIT_CYCLES.
module morse_sequencer #(
    parameter int UNIT_CYCLES = 2_400_000
) (
    input  logic       clk_24,
    input  logic       rst,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic [2:0] sym_len,
    input  logic [4:0] sym_code,
    output logic       key,
    output logic       busy,
    output logic       sym_done
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_MAX = CW'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP_EL,
        GAP_CHAR,
        GAP_WORD
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc_cnt;
    logic [1:0]    unit_cnt;
    logic [2:0]    elem_idx;
    logic [4:0]    code_r;
    logic [2:0]    len_c;
    logic [2:0]    first_idx;
    logic          unit_tick;
    logic          state_end;
    logic          accept;
    logic          key_d;
    logic          done_d;

    assign len_c     = (sym_len > 3'd5) ? 3'd5 : sym_len;
    assign first_idx = len_c - 3'd1;
    assign unit_tick = (cyc_cnt == CYC_MAX);
    // unit_cnt holds remaining units minus one, so a state ends on its last unit tick
    assign state_end = unit_tick && (unit_cnt == 2'd0);
    assign sym_ready = (state == IDLE) && !rst;
    assign accept    = sym_ready && sym_valid;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_24) begin
        if (rst) begin
            state    <= IDLE;
            key      <= 1'b0;
            sym_done <= 1'b0;
            cyc_cnt  <= '0;
            unit_cnt <= 2'd0;
            elem_idx <= 3'd0;
            code_r   <= 5'd0;
        end else begin
            state    <= state_n;
            key      <= key_d;
            sym_done <= done_d;
            if (accept) begin
                code_r   <= sym_code;
                elem_idx <= first_idx;
                cyc_cnt  <= '0;
                if (len_c == 3'd0)
                    unit_cnt <= 2'd3;
                else
                    unit_cnt <= sym_code[first_idx] ? 2'd2 : 2'd0;
            end else if (state != IDLE) begin
                cyc_cnt <= unit_tick ? '0 : cyc_cnt + CW'(1);
                if (state_end) begin
                    case (state)
                        MARK: begin
                            if (elem_idx == 3'd0) begin
                                unit_cnt <= 2'd2;
                            end else begin
                                unit_cnt <= 2'd0;
                                elem_idx <= elem_idx - 3'd1;
                            end
                        end
                        GAP_EL:  unit_cnt <= code_r[elem_idx] ? 2'd2 : 2'd0;
                        default: unit_cnt <= 2'd0;
                    endcase
                end else if (unit_tick) begin
                    unit_cnt <= unit_cnt - 2'd1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (sym_valid)
                    state_n = (len_c == 3'd0) ? GAP_WORD : MARK;
            end
            MARK: begin
                if (state_end)
                    state_n = (elem_idx == 3'd0) ? GAP_CHAR : GAP_EL;
            end
            GAP_EL: begin
                if (state_end)
                    state_n = MARK;
            end
            GAP_CHAR, GAP_WORD: begin
                if (state_end)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // key and sym_done are registered from the upcoming state
    always_comb begin
        key_d  = (state_n == MARK);
        done_d = (state != IDLE) && (state_n == IDLE);
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// tb/tb_morse_sequencer.sv - self-checking bench for morse_sequencer
module tb_morse_sequencer;

    localparam int U = 4;

    logic       clk_24 = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [2:0] sym_len = 3'd0;
    logic [4:0] sym_code = 5'd0;
    logic       key;
    logic       busy;
    logic       sym_done;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    morse_sequencer #(.UNIT_CYCLES(U)) dut (
        .clk_24   (clk_24),
        .rst      (rst),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sym_len  (sym_len),
        .sym_code (sym_code),
        .key      (key),
        .busy     (busy),
        .sym_done (sym_done)
    );

    always #5 clk_24 = ~clk_24;

    typedef struct {
        logic [2:0] len;
        logic [4:0] code;
        int         busy_cyc;
        int         key_cyc;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected per-cycle key level over the busy period of one symbol
    task automatic build_model(input logic [2:0] len, input logic [4:0] code);
        int n;
        exp_q.delete();
        n = (len > 3'd5) ? 5 : int'(len);
        if (n == 0) begin
            repeat (4 * U) exp_q.push_back(1'b0);
        end else begin
            for (int i = n - 1; i >= 0; i--) begin
                repeat ((code[i] ? 3 : 1) * U) exp_q.push_back(1'b1);
                repeat ((i > 0 ? 1 : 3) * U) exp_q.push_back(1'b0);
            end
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!sym_ready && t < 200) begin
            @(negedge clk_24);
            t++;
        end
        if (!sym_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic run_sym(input logic [2:0] len, input logic [4:0] code,
                           output int busy_n, output int key_n);
        int idx = 0;
        int bad = -1;
        int t = 0;
        build_model(len, code);
        busy_n = 0;
        key_n = 0;
        wait_ready();
        sym_len = len;
        sym_code = code;
        sym_valid = 1'b1;
        @(negedge clk_24);
        sym_valid = 1'b0;
        sym_len = $urandom_range(0, 7);
        sym_code = 5'($urandom);
        while (!sym_done && t < 200) begin
            busy_n += int'(busy);
            key_n += int'(key);
            if (bad < 0 && (idx >= exp_q.size() || key !== exp_q[idx] || busy !== 1'b1))
                bad = idx;
            idx++;
            t++;
            @(negedge clk_24);
        end
        check($sformatf("trace_first_bad_cycle len=%0d code=%b", len, code), bad, -1);
        check("trace_length", idx, exp_q.size());
        check("done_ready", int'(sym_done && sym_ready && !busy), 1);
        @(negedge clk_24);
    endtask

    initial begin
        vec_t vecs[6];
        int bn, kn, cnt;

        vecs[0] = '{3'd1, 5'b00000, 16, 4};
        vecs[1] = '{3'd2, 5'b00001, 32, 16};
        vecs[2] = '{3'd0, 5'b10101, 16, 0};
        vecs[3] = '{3'd3, 5'b00111, 56, 36};
        vecs[4] = '{3'd7, 5'b11111, 88, 60};
        vecs[5] = '{3'd6, 5'b10101, 72, 44};

        // reset state, with sym_valid asserted during reset
        sym_valid = 1'b1;
        sym_len = 3'd1;
        repeat (3) @(negedge clk_24);
        check("rst_key", int'(key), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(sym_done), 0);
        check("rst_ready", int'(sym_ready), 0);
        rst = 1'b0;
        sym_valid = 1'b0;
        @(negedge clk_24);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_ready", int'(sym_ready), 1);

        for (int i = 0; i < 6; i++) begin
            run_sym(vecs[i].len, vecs[i].code, bn, kn);
            check($sformatf("vec%0d_busy_cycles", i), bn, vecs[i].busy_cyc);
            check($sformatf("vec%0d_key_cycles", i), kn, vecs[i].key_cyc);
        end
        check("done_one_cycle", int'(sym_done), 0);

        // 'E' then 'T' with sym_valid held through the busy period
        sym_len = 3'd1;
        sym_code = 5'b00000;
        sym_valid = 1'b1;
        @(negedge clk_24);
        sym_code = 5'b00001;
        cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            cnt += int'(key);
            @(negedge clk_24);
        end
        check("et_e_key_cycles", cnt, 4);
        check("et_done", int'(sym_done && sym_ready), 1);
        @(negedge clk_24);
        sym_valid = 1'b0;
        check("et_t_key_start", int'(key), 1);
        check("et_done_clear", int'(sym_done), 0);
        cnt = 0;
        for (int c = 18; c <= 29; c++) begin
            cnt += int'(key);
            @(negedge clk_24);
        end
        check("et_t_key_cycles", cnt, 12);
        check("et_t_key_end", int'(key), 0);
        wait_ready();

        // reset in the middle of 'O'
        sym_len = 3'd3;
        sym_code = 5'b00111;
        sym_valid = 1'b1;
        @(negedge clk_24);
        sym_valid = 1'b0;
        repeat (5) @(negedge clk_24);
        rst = 1'b1;
        @(negedge clk_24);
        check("midrst_key", int'(key), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(sym_ready), 0);
        rst = 1'b0;
        @(negedge clk_24);
        check("midrst_ready_after", int'(sym_ready), 1);
        cnt = 0;
        repeat (60) begin
            cnt += int'(sym_done) + int'(busy);
            @(negedge clk_24);
        end
        check("midrst_no_done", cnt, 0);

        // randomized symbols against the model
        for (int i = 0; i < 20; i++) begin
            logic [2:0] l;
            logic [4:0] cd;
            l = 3'($urandom_range(0, 7));
            cd = 5'($urandom);
            run_sym(l, cd, bn, kn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
